// File: rtl/counter_down_load.sv
// Loadable down-counter with start/stop control, one-cycle terminal-count pulse
// and optional automatic reload from the last loaded value.
module counter_down_load #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_load,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cntNext;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reloadNext;
  logic [WIDTH-1:0] w_runCnt;
  logic             r_done;
  logic             w_doneNext;

  // In RUN a zero count only exists while auto-reloading, so the next value is
  // either the reload value or a plain decrement; the counter never wraps.
  assign w_runCnt = (r_cnt == '0) ? r_reload : (r_cnt - WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_reload <= w_reloadNext;
      r_done   <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_reloadNext = r_reload;
    w_doneNext   = 1'b0;

    if (load) begin
      w_cntNext    = data_load;
      w_reloadNext = data_load;
      w_stateNext  = IDLE;
    end else if (stop) begin
      w_stateNext = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (r_cnt == '0) begin
              w_doneNext = 1'b1;
            end else begin
              w_stateNext = RUN;
            end
          end
        end
        RUN: begin
          w_cntNext = w_runCnt;
          // auto_reload only matters on the edge that lands on terminal count
          if (w_runCnt == '0) begin
            w_doneNext = 1'b1;
            if (!auto_reload) begin
              w_stateNext = IDLE;
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  assign cnt  = r_cnt;
  assign busy = (r_state == RUN);
  assign done = r_done;

endmodule

// File: tb/tb_counter_down_load.sv
// Self-checking bench for counter_down_load: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_counter_down_load;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data_load;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;

  int testsRun;
  int testsFailed;

  // behavioural model state
  int modelCnt;
  int modelReload;
  bit modelRunning;
  bit modelDone;

  counter_down_load #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .data_load(data_load),
    .start(start),
    .stop(stop),
    .auto_reload(auto_reload),
    .cnt(cnt),
    .busy(busy),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelCnt     = 0;
    modelReload  = 0;
    modelRunning = 0;
    modelDone    = 0;
  endtask

  // One clock edge of the counter's documented behaviour, in plain integers.
  task automatic modelStep(input bit l, input int d, input bit st, input bit sp, input bit ar);
    int target;
    modelDone = 0;
    if (l) begin
      modelCnt     = d;
      modelReload  = d;
      modelRunning = 0;
    end else if (sp) begin
      modelRunning = 0;
    end else if (!modelRunning) begin
      if (st && modelCnt == 0) modelDone = 1;
      else if (st) modelRunning = 1;
    end else begin
      target   = (modelCnt > 0) ? modelCnt - 1 : modelReload;
      modelCnt = target;
      if (target == 0) begin
        modelDone = 1;
        if (!ar) modelRunning = 0;
      end
    end
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, ".cnt"}, 32'(cnt), 32'(modelCnt));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(modelRunning));
    checkOutput({tag, ".done"}, 32'(done), 32'(modelDone));
  endtask

  // Drive inputs between edges, clock once, advance the model and compare.
  task automatic applyStimulus(input bit l, input int d, input bit st, input bit sp, input bit ar, input string tag);
    load        = l;
    data_load   = WIDTH'(d);
    start       = st;
    stop        = sp;
    auto_reload = ar;
    @(posedge clk);
    modelStep(l, d, st, sp, ar);
    #1;
    compareModel(tag);
  endtask

  int seq5[7] = '{5, 5, 4, 3, 2, 1, 0};
  int seq3[9] = '{3, 3, 2, 1, 0, 3, 2, 1, 0};
  int doneCount;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b0;
    load        = 1'b0;
    data_load   = '0;
    start       = 1'b0;
    stop        = 1'b0;
    auto_reload = 1'b0;
    modelReset();

    #12;
    checkOutput("reset.cnt", 32'(cnt), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    #5 rst = 1'b1;

    applyStimulus(0, 0, 0, 0, 0, "idleAfterReset");
    applyStimulus(0, 0, 0, 1, 0, "stopInIdle");

    // load 5, single-shot countdown
    applyStimulus(1, 5, 0, 0, 0, "oneShot");
    checkOutput("oneShot.seq0", 32'(cnt), 32'(seq5[0]));
    for (int i = 1; i < 7; i++) begin
      applyStimulus(0, 0, (i == 1), 0, 0, "oneShot");
      checkOutput($sformatf("oneShot.seq%0d", i), 32'(cnt), 32'(seq5[i]));
      checkOutput($sformatf("oneShot.done%0d", i), 32'(done), 32'(i == 6));
      checkOutput($sformatf("oneShot.busy%0d", i), 32'(busy), 32'(i != 6));
    end
    applyStimulus(0, 0, 0, 0, 0, "oneShotAfter");
    checkOutput("oneShotAfter.doneLow", 32'(done), 32'd0);

    // load 3, auto-reload: period of 4 cycles
    doneCount = 0;
    applyStimulus(1, 3, 0, 0, 1, "autoReload");
    checkOutput("autoReload.seq0", 32'(cnt), 32'(seq3[0]));
    for (int i = 1; i < 9; i++) begin
      applyStimulus(0, 0, (i == 1), 0, 1, "autoReload");
      checkOutput($sformatf("autoReload.seq%0d", i), 32'(cnt), 32'(seq3[i]));
      checkOutput($sformatf("autoReload.busy%0d", i), 32'(busy), 32'd1);
      if (done) doneCount++;
    end
    checkOutput("autoReload.doneCount", 32'(doneCount), 32'd2);

    // stop at cnt 2, hold, then resume
    applyStimulus(1, 4, 0, 0, 0, "stopHold");
    applyStimulus(0, 0, 1, 0, 0, "stopHold");
    applyStimulus(0, 0, 0, 0, 0, "stopHold");
    applyStimulus(0, 0, 0, 0, 0, "stopHold");
    checkOutput("stopHold.at2", 32'(cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, "stopHold");
      checkOutput("stopHold.held", 32'(cnt), 32'd2);
      checkOutput("stopHold.idle", 32'(busy), 32'd0);
    end
    applyStimulus(0, 0, 1, 0, 0, "resume");
    checkOutput("resume.cnt2", 32'(cnt), 32'd2);
    applyStimulus(0, 0, 0, 0, 0, "resume");
    checkOutput("resume.cnt1", 32'(cnt), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, "resume");
    checkOutput("resume.cnt0", 32'(cnt), 32'd0);
    checkOutput("resume.done", 32'(done), 32'd1);

    // load, stop and start together while running
    applyStimulus(1, 9, 0, 0, 0, "priority");
    applyStimulus(0, 0, 1, 0, 0, "priority");
    applyStimulus(1, 'hA0, 1, 1, 0, "priority");
    checkOutput("priority.cnt", 32'(cnt), 32'h0A0);
    checkOutput("priority.busy", 32'(busy), 32'd0);
    checkOutput("priority.done", 32'(done), 32'd0);

    // start in IDLE with cnt 0
    applyStimulus(1, 0, 0, 0, 0, "zeroStart");
    applyStimulus(0, 0, 1, 0, 0, "zeroStart");
    checkOutput("zeroStart.done", 32'(done), 32'd1);
    checkOutput("zeroStart.busy", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, "zeroStart");
    checkOutput("zeroStart.doneOnce", 32'(done), 32'd0);
    checkOutput("zeroStart.cnt", 32'(cnt), 32'd0);

    // asynchronous reset mid-run at cnt 3
    applyStimulus(1, 5, 0, 0, 0, "midReset");
    applyStimulus(0, 0, 1, 0, 0, "midReset");
    applyStimulus(0, 0, 0, 0, 0, "midReset");
    applyStimulus(0, 0, 0, 0, 0, "midReset");
    checkOutput("midReset.at3", 32'(cnt), 32'd3);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkOutput("midReset.cnt", 32'(cnt), 32'd0);
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, "afterReset");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 12) == 0),
                    1'($urandom_range(0, 1)),
                    "random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/counter_down_load.md
COUNTER_DOWN_LOAD -- requirements
Module: counter_down_load

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the counter and load-data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port load, input, 1 bit: capture data_load into the counter and the reload register.
REQ-005 The block SHALL have port data_load, input, WIDTH bits: load value.
REQ-006 The block SHALL have port start, input, 1 bit: begin or resume counting down.
REQ-007 The block SHALL have port stop, input, 1 bit: pause counting and hold cnt.
REQ-008 The block SHALL have port auto_reload, input, 1 bit: 1 = restart from the reload value after reaching 0.
REQ-009 The block SHALL have port cnt, output, WIDTH bits: current count, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RUN, registered.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle terminal-count pulse, registered.

Function
REQ-012 The block SHALL implement a two-state FSM with states IDLE and RUN; busy SHALL be 1 exactly when the state is RUN.
REQ-013 The block SHALL give per-edge input priority in this order: load > stop > start; lower-priority inputs SHALL be ignored that edge.
REQ-014 On load, in any state, the block SHALL set cnt <= data_load, reload_val <= data_load, state <= IDLE and done <= 0.
REQ-015 On stop in RUN, the block SHALL go to IDLE with cnt held; stop in IDLE SHALL have no effect.
REQ-016 On start in IDLE with cnt != 0, the block SHALL go to RUN with cnt unchanged on that edge.
REQ-017 On start in IDLE with cnt == 0, the block SHALL pulse done for one cycle, stay in IDLE, and leave cnt at 0.
REQ-018 The block SHALL ignore start while in RUN.
REQ-019 In RUN with cnt != 0, the block SHALL decrement cnt by 1 each edge.
REQ-020 The block SHALL assert done on the edge at which cnt becomes 0 in RUN, and SHALL keep it asserted for exactly one cycle.
REQ-021 When cnt becomes 0 in RUN with auto_reload = 0, the block SHALL go to IDLE on that same edge (busy falls together with done rising).
REQ-022 When cnt becomes 0 in RUN with auto_reload = 1, the block SHALL stay in RUN, and on the next edge SHALL set cnt <= reload_val; the period SHALL be reload_val + 1 cycles.
REQ-023 With auto_reload = 1 and reload_val = 0, the block SHALL stay in RUN with cnt = 0 and done = 1 every cycle.
REQ-024 The block SHALL sample auto_reload only at the edge where cnt == 0 in RUN.
REQ-025 The block SHALL never let cnt wrap below 0; there is no underflow path.
REQ-026 When done is not being pulsed, the block SHALL drive done to 0.

Reset
REQ-027 While rst = 0, the block SHALL asynchronously force cnt = 0, reload_val = 0, state = IDLE, busy = 0 and done = 0, regardless of clk.
REQ-028 After release of rst, the block SHALL remain in IDLE until load or start; reset mid-RUN SHALL abort counting with no done pulse.

Verification
REQ-029 The bench SHALL drive rst low mid-RUN at cnt = 3, off a clock edge -> cnt = 0, busy = 0 and done = 0 immediately; the block stays in IDLE after release.
REQ-030 The bench SHALL apply load 5, then start with auto_reload = 0 -> cnt sequence 5,5,4,3,2,1,0; done = 1 for exactly the cycle cnt first reads 0; busy drops on the same edge.
REQ-031 The bench SHALL apply load 3, then start with auto_reload = 1 -> cnt 3,2,1,0,3,2,1,0,...; done pulses every 4 cycles; busy stays 1.
REQ-032 The bench SHALL apply stop at cnt = 2, hold 3 cycles, then start -> cnt stays 2 with busy = 0 during the hold, then continues 2,1,0 with done.
REQ-033 The bench SHALL assert load = 1 (data_load = 0xA0), stop = 1 and start = 1 together during RUN -> cnt = 0xA0, state IDLE, busy = 0, no done.
REQ-034 The bench SHALL apply start in IDLE with cnt = 0 -> a single done pulse, cnt = 0 and busy = 0 throughout.
